tx_burst_sched: RTL

//  Sequences one ultrasonic transmit burst across NUM_CH transducer channels, then opens a listen window.

---
 rtl/tx_burst_sched_pkg.sv | 28 ++
 rtl/tx_chan_gen.sv | 114 +++++++++++
 rtl/tx_burst_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/tx_burst_sched_pkg.sv
// Shared types for the transmit burst scheduler: FSM encodings and a width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_burst_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_LISTEN = 2'd2
   } burst_state_t;

   typedef enum logic [1:0] {
      CH_WAIT   = 2'd0,
      CH_ACTIVE = 2'd1,
      CH_FIN    = 2'd2
   } chan_state_t;

   // Bits needed to hold 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/tx_chan_gen.sv
// One transducer channel: start-delay countdown then PULSES carrier periods on a push-pull pair.
// Latency: drive starts delay+1 cycles after go_in; fin_out rises with the last drive cycle.
// Backpressure: none; abort_in parks the channel immediately with both drives low.
module tx_chan_gen
   import tx_burst_sched_pkg::*;
#(
   parameter int DLY_W       = 8,
   parameter int HALF_PERIOD = 625,
   parameter int PULSES      = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             go_in,
   input  logic             abort_in,
   input  logic [DLY_W-1:0] delay_in,
   output logic             drv_p_out,
   output logic             drv_n_out,
   output logic             fin_out
);

   localparam int HP_W = clog2_min1(HALF_PERIOD);
   localparam int HC_W = clog2_min1(2 * PULSES);
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * PULSES - 1);

   chan_state_t      ch_q;
   chan_state_t      ch_nxt;
   logic [DLY_W-1:0] dly_cnt;
   logic [HP_W-1:0]  hp_cnt;
   logic [HC_W-1:0]  hc_cnt;
   logic             hp_end;
   logic             hc_end;

   assign hp_end = (hp_cnt == HP_LAST);
   assign hc_end = (hc_cnt == HC_LAST);

   // Next channel state: go re-arms, abort parks, WAIT -> ACTIVE -> FIN otherwise
   always_comb begin
      ch_nxt = ch_q;
      if (abort_in) begin
         ch_nxt = CH_FIN;
      end else if (go_in) begin
         ch_nxt = CH_WAIT;
      end else begin
         case (ch_q)
            CH_WAIT:   if (dly_cnt == '0) ch_nxt = CH_ACTIVE;
            CH_ACTIVE: if (hp_end && hc_end) ch_nxt = CH_FIN;
            default:   ch_nxt = ch_q;
         endcase
      end
   end

   // Channel state register; FIN doubles as the idle state between bursts
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) ch_q <= CH_FIN;
      else           ch_q <= ch_nxt;
   end

   // Counters and registered drive pair; fin is raised one edge early so it
   // coincides with the last driven cycle and the top can leave RUN right after
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         dly_cnt   <= '0;
         hp_cnt    <= '0;
         hc_cnt    <= '0;
         drv_p_out <= 1'b0;
         drv_n_out <= 1'b0;
         fin_out   <= 1'b0;
      end else if (abort_in) begin
         drv_p_out <= 1'b0;
         drv_n_out <= 1'b0;
         fin_out   <= 1'b0;
      end else if (go_in) begin
         dly_cnt   <= delay_in;
         hp_cnt    <= '0;
         hc_cnt    <= '0;
         drv_p_out <= 1'b0;
         drv_n_out <= 1'b0;
         fin_out   <= 1'b0;
      end else begin
         case (ch_q)
            CH_WAIT: begin
               if (dly_cnt == '0) begin
                  drv_p_out <= 1'b1;
                  drv_n_out <= 1'b0;
                  hp_cnt    <= '0;
                  hc_cnt    <= '0;
               end else begin
                  dly_cnt <= dly_cnt - 1'b1;
               end
            end
            CH_ACTIVE: begin
               if (hp_end) begin
                  if (hc_end) begin
                     drv_p_out <= 1'b0;
                     drv_n_out <= 1'b0;
                  end else begin
                     hp_cnt    <= '0;
                     hc_cnt    <= hc_cnt + 1'b1;
                     drv_p_out <= ~drv_p_out;
                     drv_n_out <= drv_p_out;
                     fin_out   <= (HP_LAST == '0) && (hc_cnt + 1'b1 == HC_LAST);
                  end
               end else begin
                  hp_cnt  <= hp_cnt + 1'b1;
                  fin_out <= (hp_cnt + 1'b1 == HP_LAST) && hc_end;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tx_burst_sched.sv
// Transmit burst sequencer: steered start across NUM_CH channels, then a listen window.
// Latency: busy the edge start is accepted; listen one edge after the last channel ends.
// Backpressure: start ignored while busy (not queued); abort clears everything at once.
module tx_burst_sched
   import tx_burst_sched_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DLY_W       = 8,
   parameter int HALF_PERIOD = 625,
   parameter int PULSES      = 8,
   parameter int LISTEN_CYC  = 4096
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    start_in,
   input  logic                    abort_in,
   input  logic [NUM_CH*DLY_W-1:0] delay_in,
   output logic [NUM_CH-1:0]       drv_p_out,
   output logic [NUM_CH-1:0]       drv_n_out,
   output logic                    busy_out,
   output logic                    listen_out,
   output logic                    done_out
);

   localparam int LS_W = clog2_min1(LISTEN_CYC);
   localparam logic [LS_W-1:0] LS_LAST = LS_W'(LISTEN_CYC - 1);

   burst_state_t    st_q;
   burst_state_t    st_nxt;
   logic            go;
   logic [NUM_CH-1:0] fin;
   logic            busy_nxt;
   logic            listen_nxt;
   logic            done_nxt;
   logic [LS_W-1:0] ls_cnt;
   logic [LS_W-1:0] ls_nxt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tx_chan_gen #(
         .DLY_W       (DLY_W),
         .HALF_PERIOD (HALF_PERIOD),
         .PULSES      (PULSES)
      ) u_chan (
         .clk_in    (clk_in),
         .rst_n_in  (rst_n_in),
         .go_in     (go),
         .abort_in  (abort_in),
         .delay_in  (delay_in[i*DLY_W +: DLY_W]),
         .drv_p_out (drv_p_out[i]),
         .drv_n_out (drv_n_out[i]),
         .fin_out   (fin[i])
      );
   end

   // Next state and next registered status outputs; abort overrides start in every state
   always_comb begin
      st_nxt     = st_q;
      busy_nxt   = busy_out;
      listen_nxt = listen_out;
      done_nxt   = 1'b0;
      ls_nxt     = ls_cnt;
      go         = 1'b0;
      if (abort_in) begin
         st_nxt     = ST_IDLE;
         busy_nxt   = 1'b0;
         listen_nxt = 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (start_in) begin
                  go       = 1'b1;
                  st_nxt   = ST_RUN;
                  busy_nxt = 1'b1;
               end
            end
            ST_RUN: begin
               if (&fin) begin
                  st_nxt     = ST_LISTEN;
                  listen_nxt = 1'b1;
                  ls_nxt     = '0;
               end
            end
            ST_LISTEN: begin
               if (ls_cnt == LS_LAST) begin
                  st_nxt     = ST_IDLE;
                  busy_nxt   = 1'b0;
                  listen_nxt = 1'b0;
                  done_nxt   = 1'b1;
               end else begin
                  ls_nxt = ls_cnt + 1'b1;
               end
            end
            default: st_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM state, listen counter and status output registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         st_q       <= ST_IDLE;
         ls_cnt     <= '0;
         busy_out   <= 1'b0;
         listen_out <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         st_q       <= st_nxt;
         ls_cnt     <= ls_nxt;
         busy_out   <= busy_nxt;
         listen_out <= listen_nxt;
         done_out   <= done_nxt;
      end
   end

endmodule
